// File: rtl/is_pkg.sv
// Shared types and constants for the interactive-score fabric: point states
// and the default global_clock width used by point and interval blocks.
package is_pkg;

    localparam int unsigned IS_WIDTH = 32;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b0000001,
        ST_WAIT_IN = 7'b0000010,
        ST_ARMED   = 7'b0000100,
        ST_FIRE    = 7'b0001000,
        ST_DONE    = 7'b0010000,
        ST_SKIPPED = 7'b0100000,
        ST_KILLED  = 7'b1000000
    } point_state_t;

endpackage

// File: rtl/sync_point_ctrl_input_tracker.sv
// One incoming-interval slot: sticky min/fin/skp/kil flags and their
// next-value view (sticky OR same-cycle accepted pulse).
module point_input_tracker (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    input  logic min_i,
    input  logic fin_i,
    input  logic skp_i,
    input  logic kil_i,
    output logic min_nv_o,
    output logic fin_nv_o,
    output logic skp_nv_o,
    output logic kil_nv_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] pulse_s;

    assign pulse_s = en_i ? {kil_i, skp_i, fin_i, min_i} : 4'b0000;

    // Sticky flag update: clear wins over any accepted pulse.
    always_comb begin
        flags_d = flags_q;
        if (clear_i) begin
            flags_d = 4'b0000;
        end else begin
            flags_d = flags_q | pulse_s;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign min_nv_o = flags_q[0] | pulse_s[0];
    assign fin_nv_o = flags_q[1] | pulse_s[1];
    assign skp_nv_o = flags_q[2] | pulse_s[2];
    assign kil_nv_o = flags_q[3] | pulse_s[3];

endmodule

// File: rtl/sync_point_ctrl.sv
// Temporal point controller: merges incoming interval status into a
// fire / skip / kill decision and drives the outgoing intervals.
module sync_point_ctrl
    import is_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned WIDTH = IS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             clear,
    input  logic             go,
    input  logic             interactive,
    input  logic             user_event,
    input  logic [N_IN-1:0]  in_mask,
    input  logic [N_OUT-1:0] out_mask,
    input  logic [N_IN-1:0]  in_min_elapsed,
    input  logic [N_IN-1:0]  in_finished,
    input  logic [N_IN-1:0]  in_skip,
    input  logic [N_IN-1:0]  in_kill,
    input  logic [WIDTH-1:0] global_clock,
    output logic [N_OUT-1:0] start_out,
    output logic [N_OUT-1:0] skip_out,
    output logic [N_OUT-1:0] kill_out,
    output logic [N_IN-1:0]  ext_e_out,
    output logic             fired,
    output logic [WIDTH-1:0] fire_time,
    output logic             busy
);

    point_state_t     state_q, state_d;
    logic [N_IN-1:0]  in_mask_q, in_mask_d;
    logic [N_OUT-1:0] out_mask_q, out_mask_d;
    logic             interactive_q, interactive_d;
    logic             fired_q, fired_d;
    logic [WIDTH-1:0] fire_time_q, fire_time_d;

    logic             accept_s;
    logic             clear_eff_s;
    logic             start_arm_s;
    logic             trk_clear_s;
    logic [N_IN-1:0]  min_nv_s, fin_nv_s, skp_nv_s, kil_nv_s;
    logic             resolved_s, ready_s, live_s, any_kil_s, all_skp_s, src_s;
    logic [N_IN-1:0]  ext_e_s;

    assign accept_s    = (state_q == ST_WAIT_IN) || (state_q == ST_ARMED);
    assign clear_eff_s = clear && (state_q != ST_IDLE);
    assign start_arm_s = arm && (state_q == ST_IDLE);
    // Sticky flags are wiped on clear and again on arm so each run starts fresh.
    assign trk_clear_s = clear_eff_s || start_arm_s;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_trk
            point_input_tracker u_trk (
                .clk      (clk),
                .rst      (rst),
                .clear_i  (trk_clear_s),
                .en_i     (accept_s && in_mask_q[gi]),
                .min_i    (in_min_elapsed[gi]),
                .fin_i    (in_finished[gi]),
                .skp_i    (in_skip[gi]),
                .kil_i    (in_kill[gi]),
                .min_nv_o (min_nv_s[gi]),
                .fin_nv_o (fin_nv_s[gi]),
                .skp_nv_o (skp_nv_s[gi]),
                .kil_nv_o (kil_nv_s[gi])
            );
        end
    endgenerate

    // Unused slots count as satisfied for the AND terms and never as live.
    assign resolved_s = &(~in_mask_q | fin_nv_s | skp_nv_s);
    assign ready_s    = &(~in_mask_q | min_nv_s | fin_nv_s | skp_nv_s);
    assign live_s     = |(in_mask_q & ~skp_nv_s);
    assign any_kil_s  = |(in_mask_q & kil_nv_s);
    assign all_skp_s  = (|in_mask_q) && (&(~in_mask_q | skp_nv_s));
    assign src_s      = ~(|in_mask_q);

    // Next-state decision and the combinational external_e return path.
    always_comb begin
        state_d = state_q;
        ext_e_s = {N_IN{1'b0}};
        if (clear_eff_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_WAIT_IN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_IN: begin
                    if (any_kil_s) begin
                        state_d = ST_KILLED;
                    end else if (all_skp_s) begin
                        state_d = ST_SKIPPED;
                    end else if (src_s) begin
                        state_d = go ? ST_FIRE : ST_WAIT_IN;
                    end else if (!interactive_q && resolved_s && live_s) begin
                        state_d = ST_FIRE;
                    end else if (interactive_q && ready_s && live_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_WAIT_IN;
                    end
                end
                ST_ARMED: begin
                    if (any_kil_s) begin
                        state_d = ST_KILLED;
                    end else if (all_skp_s) begin
                        state_d = ST_SKIPPED;
                    end else if (user_event) begin
                        ext_e_s = in_mask_q;
                        state_d = ST_FIRE;
                    end else if (resolved_s) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_FIRE:    state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                ST_SKIPPED: state_d = ST_SKIPPED;
                ST_KILLED:  state_d = ST_KILLED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Latched configuration and fire record.
    always_comb begin
        in_mask_d     = in_mask_q;
        out_mask_d    = out_mask_q;
        interactive_d = interactive_q;
        fired_d       = fired_q;
        fire_time_d   = fire_time_q;
        if (clear_eff_s) begin
            in_mask_d     = {N_IN{1'b0}};
            out_mask_d    = {N_OUT{1'b0}};
            interactive_d = 1'b0;
            fired_d       = 1'b0;
            fire_time_d   = {WIDTH{1'b0}};
        end else if (start_arm_s) begin
            in_mask_d     = in_mask;
            out_mask_d    = out_mask;
            interactive_d = interactive;
        end else if (state_q == ST_FIRE) begin
            fired_d     = 1'b1;
            fire_time_d = global_clock;
        end else begin
            fired_d = fired_q;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_mask_q     <= {N_IN{1'b0}};
            out_mask_q    <= {N_OUT{1'b0}};
            interactive_q <= 1'b0;
            fired_q       <= 1'b0;
            fire_time_q   <= {WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            in_mask_q     <= in_mask_d;
            out_mask_q    <= out_mask_d;
            interactive_q <= interactive_d;
            fired_q       <= fired_d;
            fire_time_q   <= fire_time_d;
        end
    end

    // Level outputs decode the registered state so reset drops them at once.
    assign start_out = (state_q == ST_FIRE)    ? out_mask_q : {N_OUT{1'b0}};
    assign skip_out  = (state_q == ST_SKIPPED) ? out_mask_q : {N_OUT{1'b0}};
    assign kill_out  = (state_q == ST_KILLED)  ? out_mask_q : {N_OUT{1'b0}};
    assign ext_e_out = ext_e_s;
    assign fired     = fired_q;
    assign fire_time = fire_time_q;
    assign busy      = (state_q == ST_WAIT_IN) || (state_q == ST_ARMED);

endmodule
